// File: rtl/nios2_debug_cmd_sync.sv
// nios2_debug_cmd_sync: carries JTAG update-DR/IR events into clk and
// buffers captured {ir_in, sr} commands in a show-ahead FIFO.
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   vs_udr, vs_uir      JTAG-domain update levels (asynchronous)
//   ir_in, sr           JTAG instruction / data, quasi-static
//   cmd_valid/ready     head-of-FIFO handshake
//   cmd_ir, jdo         head command instruction and data
//   cmd_sel             one-hot of cmd_ir, gated by cmd_valid
//   ir_update           one-cycle pulse per update-IR event
//   ir_latched          ir_in captured at the last ir_update
//   fifo_level          buffered command count
//   overflow            sticky dropped-command flag
//   overflow_clr        clears overflow (a same-cycle drop wins)
module nios2_debug_cmd_sync #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [SR_WIDTH-1:0]           sr,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [SR_WIDTH-1:0]           jdo,
  output logic [2**IR_WIDTH-1:0]        cmd_sel,
  output logic                          ir_update,
  output logic [IR_WIDTH-1:0]           ir_latched,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int EW   = IR_WIDTH + SR_WIDTH;
  localparam int NSEL = 2**IR_WIDTH;

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_prev;
  logic                   uir_prev;
  logic                   udr_edge;
  logic                   uir_edge;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_prev;
  assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_prev;

  assign full      = (level == LW'(FIFO_DEPTH));
  assign cmd_valid = (level != '0);
  assign pop       = cmd_valid & cmd_ready;
  // A full FIFO still accepts a push when the head leaves this cycle.
  assign push      = udr_edge & (~full | pop);
  assign drop      = udr_edge & full & ~pop;

  assign {cmd_ir, jdo} = mem[rd_ptr];
  assign fifo_level    = level;

  for (genvar k = 0; k < NSEL; k++) begin : g_sel
    assign cmd_sel[k] = cmd_valid & (cmd_ir == IR_WIDTH'(k));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {ir_in, sr};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      udr_sync   <= '0;
      uir_sync   <= '0;
      udr_prev   <= 1'b0;
      uir_prev   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      ir_update  <= 1'b0;
      ir_latched <= '0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_prev <= udr_sync[SYNC_STAGES-1];
      uir_prev <= uir_sync[SYNC_STAGES-1];

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end

      ir_update <= uir_edge;
      if (uir_edge) begin
        ir_latched <= ir_in;
      end
    end
  end

endmodule

// File: doc/nios2_debug_cmd_sync.md
NIOS2_DEBUG_CMD_SYNC -- requirements
Module: nios2_debug_cmd_sync

Interface
REQ-001 Parameter SR_WIDTH, default 38: width of the captured JTAG data shift register.
REQ-002 Parameter IR_WIDTH, default 2: width of the virtual JTAG instruction register.
REQ-003 Parameter SYNC_STAGES, default 2 (legal 2..4): synchroniser flop count on vs_udr/vs_uir.
REQ-004 Parameter FIFO_DEPTH, default 4 (power of two, 2..16): command buffer depth.
REQ-005 One clock, clk; reset is synchronous and active-low, reset_n, sampled on the rising edge of clk.
REQ-006 Port: clk, input, 1, system clock.
REQ-007 Port: reset_n, input, 1, synchronous active-low reset.
REQ-008 Port: vs_udr, input, 1, JTAG-domain update-DR level, asynchronous to clk.
REQ-009 Port: vs_uir, input, 1, JTAG-domain update-IR level, asynchronous to clk.
REQ-010 Port: ir_in, input, IR_WIDTH, JTAG instruction, quasi-static while a vs_udr/vs_uir level is high.
REQ-011 Port: sr, input, SR_WIDTH, JTAG data register, quasi-static while a vs_udr/vs_uir level is high.
REQ-012 Port: cmd_valid, output, 1, FIFO head holds a command.
REQ-013 Port: cmd_ready, input, 1, consumer accepts the head command.
REQ-014 Port: cmd_ir, output, IR_WIDTH, instruction of the head command.
REQ-015 Port: jdo, output, SR_WIDTH, data of the head command.
REQ-016 Port: cmd_sel, output, 2**IR_WIDTH, one-hot decode of cmd_ir, gated by cmd_valid.
REQ-017 Port: ir_update, output, 1, one-cycle pulse on each synchronised vs_uir rising edge.
REQ-018 Port: ir_latched, output, IR_WIDTH, ir_in value captured at the last ir_update.
REQ-019 Port: fifo_level, output, $clog2(FIFO_DEPTH)+1, number of buffered commands.
REQ-020 Port: overflow, output, 1, sticky: a command was dropped.
REQ-021 Port: overflow_clr, input, 1, clears overflow.

Function
REQ-022 Each of vs_udr and vs_uir SHALL pass through SYNC_STAGES flops; a further flop holds the previous synchronised value, and a rising edge is last-stage high AND previous-stage low.
REQ-023 On a udr edge cycle, {ir_in, sr} SHALL be sampled directly from the ports and pushed into the FIFO.
REQ-024 For an empty FIFO, cmd_valid SHALL rise exactly SYNC_STAGES+1 clk edges after the first edge that samples vs_udr high.
REQ-025 The FIFO SHALL be show-ahead: cmd_ir and jdo present the head entry combinationally whenever cmd_valid=1.
REQ-026 A pop SHALL occur on a cycle with cmd_valid=1 and cmd_ready=1, and the next entry (if any) SHALL be presented on the following cycle.
REQ-027 cmd_valid SHALL depend only on FIFO state and SHALL NOT depend on cmd_ready.
REQ-028 cmd_sel[k] SHALL be 1 iff cmd_valid=1 and cmd_ir=k; otherwise cmd_sel SHALL be all zeros.
REQ-029 Push while full and popping in the same cycle: both SHALL occur and fifo_level SHALL be unchanged.
REQ-030 Push while full without a pop: the new command SHALL be dropped, the FIFO SHALL be unchanged, and overflow SHALL be set on the next edge.
REQ-031 Push and pop on a non-empty, non-full FIFO in the same cycle SHALL leave fifo_level unchanged.
REQ-032 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-033 overflow_clr=1 SHALL clear overflow on the next edge; if a drop occurs in the same cycle, set SHALL win.
REQ-034 On a uir edge cycle, ir_latched SHALL load ir_in and ir_update SHALL pulse high for exactly one cycle, registered one edge after detection.
REQ-035 uir handling SHALL be independent of the FIFO and SHALL NOT push an entry.
REQ-036 Coincident udr and uir edges SHALL both be processed in the same cycle.
REQ-037 A vs_udr level held high SHALL produce exactly one push; re-arming requires the synchronised level to return low.

Reset
REQ-038 While reset_n=0 at a clk edge, all synchroniser flops, the previous-value flops, FIFO pointers, fifo_level, overflow, ir_update and ir_latched SHALL clear to 0.
REQ-039 Consequently cmd_valid=0 and cmd_sel=0 after reset; jdo and cmd_ir are don't-care while cmd_valid=0.
REQ-040 Reset asserted mid-operation SHALL discard all buffered commands; a vs_udr level still high when reset releases SHALL produce exactly one push, after SYNC_STAGES+1 edges.

Verification
REQ-041 Defaults; ir_in=2'b01, sr=38'h2A_1234_5678, vs_udr high for 10 clk, cmd_ready=0 -> cmd_valid at edge 3, jdo=38'h2A_1234_5678, cmd_sel=4'b0010, fifo_level=1.
REQ-042 Five udr pulses with distinct sr values, cmd_ready=0 -> fifo_level=4, overflow=1, the fifth command is absent; then cmd_ready=1 -> the four commands drain in order, and cmd_valid=0 after four pops.
REQ-043 FIFO full; fifth udr edge coincides with a pop -> fifo_level stays 4, overflow=0, and the fifth value is delivered last.
REQ-044 vs_uir pulse with ir_in=2'b11 coincident with a udr edge -> ir_update high for 1 cycle, ir_latched=2'b11, fifo_level increments by 1.
REQ-045 overflow=1; overflow_clr=1 in the same cycle as a dropped push -> overflow stays 1; overflow_clr=1 alone -> overflow=0 next cycle.
REQ-046 reset_n=0 for 1 cycle with 3 buffered commands and vs_udr held high -> fifo_level=0 immediately after reset, then exactly 1 push SYNC_STAGES+1 edges after release.
